// File: rtl/mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mem_sequencer
// Brief    : Sequences load/store and pointer-indirect accesses onto a
//            handshake memory port, with byte-lane formatting and a timeout.
// Revision : 1.0 - initial release
// ============================================================================
module mem_sequencer #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic                  req_byte,
    input  logic                  req_sext,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  done,
    output logic                  err,
    output logic [DATA_W-1:0]     rdata,
    output logic [ADDR_W-1:0]     mem_address,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_byte_enable,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_resp
);

    localparam int c_lanes = DATA_W / 8;
    localparam int c_lb    = (c_lanes > 1) ? $clog2(c_lanes) : 1;
    localparam int c_cnt_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_cnt_w-1:0] c_to_last = c_cnt_w'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_IND  = 3'd1,
        S_RD   = 3'd2,
        S_WR   = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic                  store_q, store_d;
    logic                  byte_q, byte_d;
    logic                  sext_q, sext_d;
    logic                  err_q, err_d;
    logic [c_cnt_w-1:0]    wait_q, wait_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic [ADDR_W-1:0]     mem_address_q, mem_address_d;
    logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
    logic [c_lanes-1:0]    mem_be_q, mem_be_d;

    logic [ADDR_W-1:0]     w_ptr;
    logic [7:0]            w_byte;
    logic [DATA_W-1:0]     w_byte_ext;
    logic                  w_timeout;

    // Word accesses are aligned by clearing the lane-select bits.
    function automatic logic [ADDR_W-1:0] fmt_addr(input logic [ADDR_W-1:0] a,
                                                   input logic byt);
        logic [ADDR_W-1:0] r;
        r = a;
        if (!byt) begin
            r[c_lb-1:0] = '0;
        end
        return r;
    endfunction

    function automatic logic [c_lanes-1:0] fmt_be(input logic [c_lb-1:0] lane,
                                                  input logic byt);
        logic [c_lanes-1:0] r;
        if (byt) begin
            r       = '0;
            r[lane] = 1'b1;
        end else begin
            r = '1;
        end
        return r;
    endfunction

    generate
        if (ADDR_W <= DATA_W) begin : g_ptr_narrow
            assign w_ptr = mem_rdata[ADDR_W-1:0];
        end else begin : g_ptr_wide
            assign w_ptr = {{(ADDR_W-DATA_W){1'b0}}, mem_rdata};
        end
    endgenerate

    assign w_byte     = mem_rdata[{mem_address_q[c_lb-1:0], 3'b000} +: 8];
    assign w_byte_ext = {{(DATA_W-8){sext_q & w_byte[7]}}, w_byte};
    assign w_timeout  = (TIMEOUT > 0) && (wait_q == c_to_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            store_q       <= 1'b0;
            byte_q        <= 1'b0;
            sext_q        <= 1'b0;
            err_q         <= 1'b0;
            wait_q        <= '0;
            rdata_q       <= '0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            mem_be_q      <= '0;
        end else begin
            state_q       <= state_d;
            store_q       <= store_d;
            byte_q        <= byte_d;
            sext_q        <= sext_d;
            err_q         <= err_d;
            wait_q        <= wait_d;
            rdata_q       <= rdata_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_be_q      <= mem_be_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        store_d       = store_q;
        byte_d        = byte_q;
        sext_d        = sext_q;
        err_d         = err_q;
        wait_d        = wait_q;
        rdata_d       = rdata_q;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        mem_be_d      = mem_be_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    store_d       = req_op[0];
                    byte_d        = req_byte;
                    sext_d        = req_sext;
                    err_d         = 1'b0;
                    wait_d        = '0;
                    // The pointer fetch of an indirect op is always a word read.
                    mem_address_d = fmt_addr(req_addr, req_byte & ~req_op[1]);
                    mem_be_d      = fmt_be(req_addr[c_lb-1:0], req_byte & ~req_op[1]);
                    mem_wdata_d   = req_byte ? {c_lanes{req_wdata[7:0]}} : req_wdata;
                    if (req_op[1]) begin
                        state_d = S_IND;
                    end else if (req_op[0]) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_IND: begin
                if (mem_resp) begin
                    mem_address_d = fmt_addr(w_ptr, byte_q);
                    mem_be_d      = fmt_be(w_ptr[c_lb-1:0], byte_q);
                    wait_d        = '0;
                    state_d       = store_q ? S_WR : S_RD;
                end else if (w_timeout) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = S_RESP;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_RD: begin
                if (mem_resp) begin
                    rdata_d = byte_q ? w_byte_ext : mem_rdata;
                    state_d = S_RESP;
                end else if (w_timeout) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = S_RESP;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_WR: begin
                if (mem_resp) begin
                    state_d = S_RESP;
                end else if (w_timeout) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = S_RESP;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign req_ready       = (state_q == S_IDLE);
    assign done            = (state_q == S_RESP);
    assign err             = done & err_q;
    assign rdata           = rdata_q;
    assign mem_read        = (state_q == S_IND) || (state_q == S_RD);
    assign mem_write       = (state_q == S_WR);
    assign mem_address     = mem_address_q;
    assign mem_wdata       = mem_wdata_q;
    assign mem_byte_enable = mem_be_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_sequencer
// Brief    : Directed vector table, reset sequences and random transactions
//            checked against a behavioural memory/sequencer model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_sequencer;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int TO = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           req_valid;
    logic           req_ready;
    logic [1:0]     req_op;
    logic           req_byte;
    logic           req_sext;
    logic [AW-1:0]  req_addr;
    logic [DW-1:0]  req_wdata;
    logic           done;
    logic           err;
    logic [DW-1:0]  rdata;
    logic [AW-1:0]  mem_address;
    logic           mem_read;
    logic           mem_write;
    logic [DW-1:0]  mem_wdata;
    logic [1:0]     mem_byte_enable;
    logic [DW-1:0]  mem_rdata;
    logic           mem_resp;

    int total = 0;
    int bad   = 0;

    logic [15:0] mem [0:32767];

    typedef struct {
        logic [1:0]  op;
        logic        byt;
        logic        sext;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          d0;
        int          d1;
    } txn_t;

    typedef struct {
        int          n_acc;
        logic [15:0] addr0;
        logic [15:0] addr1;
        logic [1:0]  be_last;
        logic        wr_last;
        logic [15:0] wdata;
        logic [15:0] rdata;
        logic        err;
        int          done_cyc;
    } res_t;

    typedef struct {
        txn_t        t;
        logic [15:0] v0;
        logic [15:0] v1;
        res_t        e;
    } vec_t;

    vec_t vecs[$];

    mem_sequencer #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_op          (req_op),
        .req_byte        (req_byte),
        .req_sext        (req_sext),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .done            (done),
        .err             (err),
        .rdata           (rdata),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    function automatic res_t clr_res();
        res_t r;
        r.n_acc = 0; r.addr0 = '0; r.addr1 = '0; r.be_last = '0; r.wr_last = 1'b0;
        r.wdata = '0; r.rdata = '0; r.err = 1'b0; r.done_cyc = 0;
        return r;
    endfunction

    // Expected outcome from the access rules and the current memory contents.
    function automatic res_t model(input txn_t t);
        res_t        e;
        logic [15:0] a, da, w;
        logic [7:0]  b;
        int          ncyc, dly;
        e    = clr_res();
        a    = t.addr;
        ncyc = 0;
        if (t.op[1]) begin
            e.n_acc = 1; e.addr0 = {a[15:1], 1'b0}; e.be_last = 2'b11; e.wr_last = 1'b0;
            if (t.d0 >= TO) begin
                ncyc = TO; e.err = 1'b1;
            end else begin
                ncyc = t.d0 + 1; a = mem[a[15:1]];
            end
        end
        if (!e.err) begin
            da = t.byt ? a : {a[15:1], 1'b0};
            if (e.n_acc == 0) e.addr0 = da; else e.addr1 = da;
            e.n_acc   = e.n_acc + 1;
            e.be_last = !t.byt ? 2'b11 : (a[0] ? 2'b10 : 2'b01);
            e.wr_last = t.op[0];
            if (t.op[0]) e.wdata = t.byt ? {2{t.wdata[7:0]}} : t.wdata;
            dly = t.op[1] ? t.d1 : t.d0;
            if (dly >= TO) begin
                ncyc = ncyc + TO; e.err = 1'b1;
            end else begin
                ncyc = ncyc + dly + 1;
                if (!t.op[0]) begin
                    w = mem[a[15:1]];
                    b = a[0] ? w[15:8] : w[7:0];
                    e.rdata = !t.byt ? w : ((t.sext && b[7]) ? {8'hFF, b} : {8'h00, b});
                end
            end
        end
        e.done_cyc = ncyc + 1;
        return e;
    endfunction

    // Issues one request and plays the memory; fl collects protocol violations.
    task automatic run_txn(input string tag, input txn_t t, output res_t o, output logic [4:0] fl);
        int          cyc, wcnt, dly;
        logic        new_acc, seen;
        logic [15:0] ca, cw, w;
        logic [1:0]  cb;
        o  = clr_res();
        fl = '0;
        ca = '0; cw = '0; cb = '0;
        @(negedge clk);
        chk({tag, ".ready_idle"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_op = t.op; req_byte = t.byt; req_sext = t.sext;
        req_addr  = t.addr; req_wdata = t.wdata; mem_resp = 1'b0;
        cyc = 0; wcnt = 0; new_acc = 1'b1; seen = 1'b0;
        while (!seen && cyc < 64) begin
            @(negedge clk);
            cyc = cyc + 1;
            req_valid = 1'($urandom); req_op = 2'($urandom); req_byte = 1'($urandom);
            req_sext  = 1'($urandom); req_addr = 16'($urandom); req_wdata = 16'($urandom);
            if (req_ready) fl[0] = 1'b1;
            if (err && !done) fl[1] = 1'b1;
            if (mem_read && mem_write) fl[2] = 1'b1;
            if (mem_read || mem_write) begin
                if (done) fl[2] = 1'b1;
                if (new_acc) begin
                    if (o.n_acc == 0) o.addr0 = mem_address; else o.addr1 = mem_address;
                    o.n_acc = o.n_acc + 1;
                    ca = mem_address; cb = mem_byte_enable; cw = mem_wdata;
                    wcnt = 0; new_acc = 1'b0;
                end else if (ca !== mem_address || cb !== mem_byte_enable || cw !== mem_wdata) begin
                    fl[3] = 1'b1;
                end
                o.be_last = mem_byte_enable;
                o.wr_last = mem_write;
                if (mem_write) o.wdata = mem_wdata;
                dly = (o.n_acc == 1) ? t.d0 : t.d1;
                if (wcnt == dly) begin
                    w         = mem[mem_address[15:1]];
                    mem_resp  = 1'b1;
                    mem_rdata = w;
                    if (mem_write) begin
                        if (mem_byte_enable[0]) w[7:0]  = mem_wdata[7:0];
                        if (mem_byte_enable[1]) w[15:8] = mem_wdata[15:8];
                        mem[mem_address[15:1]] = w;
                    end
                    new_acc = 1'b1;
                end else begin
                    mem_resp  = 1'b0;
                    mem_rdata = 16'($urandom);
                    wcnt      = wcnt + 1;
                end
            end else begin
                mem_resp  = 1'($urandom);
                mem_rdata = 16'($urandom);
                if (done) begin
                    o.rdata = rdata; o.err = err; o.done_cyc = cyc; seen = 1'b1;
                end
            end
        end
        if (!seen) fl[4] = 1'b1;
        req_valid = 1'b0;
        mem_resp  = 1'b0;
    endtask

    task automatic compare(input string tag, input txn_t t, input res_t o, input res_t e,
                           input logic [4:0] fl);
        chk({tag, ".done_cyc"}, 32'(o.done_cyc), 32'(e.done_cyc));
        chk({tag, ".err"},      32'(o.err),      32'(e.err));
        chk({tag, ".n_acc"},    32'(o.n_acc),    32'(e.n_acc));
        chk({tag, ".addr0"},    32'(o.addr0),    32'(e.addr0));
        if (e.n_acc > 1) chk({tag, ".addr1"}, 32'(o.addr1), 32'(e.addr1));
        chk({tag, ".be"},       32'(o.be_last),  32'(e.be_last));
        chk({tag, ".is_write"}, 32'(o.wr_last),  32'(e.wr_last));
        if (e.wr_last) chk({tag, ".wdata"}, 32'(o.wdata), 32'(e.wdata));
        if (!t.op[0] || e.err) chk({tag, ".rdata"}, 32'(o.rdata), 32'(e.rdata));
        chk({tag, ".protocol"}, 32'(fl), 32'd0);
    endtask

    task automatic add_vec(input logic [1:0] op, input logic byt, input logic sext,
                           input logic [15:0] addr, input logic [15:0] wdata,
                           input int d0, input int d1, input logic [15:0] v0, input logic [15:0] v1,
                           input int n, input logic [15:0] a0, input logic [15:0] a1,
                           input logic [1:0] be, input logic wr, input logic [15:0] wd,
                           input logic [15:0] rd, input logic er, input int dc);
        vec_t v;
        v.t.op = op; v.t.byt = byt; v.t.sext = sext; v.t.addr = addr; v.t.wdata = wdata;
        v.t.d0 = d0; v.t.d1 = d1; v.v0 = v0; v.v1 = v1;
        v.e.n_acc = n; v.e.addr0 = a0; v.e.addr1 = a1; v.e.be_last = be; v.e.wr_last = wr;
        v.e.wdata = wd; v.e.rdata = rd; v.e.err = er; v.e.done_cyc = dc;
        vecs.push_back(v);
    endtask

    function automatic int pick_delay();
        return ($urandom_range(0, 7) == 0) ? 99 : int'($urandom_range(0, 4));
    endfunction

    initial begin
        res_t        o, e;
        logic [4:0]  fl;
        txn_t        t;
        logic        seen;

        reset = 1'b1; req_valid = 1'b0; req_op = '0; req_byte = 1'b0; req_sext = 1'b0;
        req_addr = '0; req_wdata = '0; mem_resp = 1'b0; mem_rdata = '0;
        for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);

        repeat (3) @(negedge clk);
        chk("rst.req_ready", 32'(req_ready),       32'd1);
        chk("rst.done",      32'(done),            32'd0);
        chk("rst.err",       32'(err),             32'd0);
        chk("rst.mem_read",  32'(mem_read),        32'd0);
        chk("rst.mem_write", 32'(mem_write),       32'd0);
        chk("rst.rdata",     32'(rdata),           32'd0);
        chk("rst.mem_addr",  32'(mem_address),     32'd0);
        chk("rst.mem_wdata", 32'(mem_wdata),       32'd0);
        chk("rst.mem_be",    32'(mem_byte_enable), 32'd0);
        reset = 1'b0;

        //       op    b    s    addr      wdata     d0  d1  v0        v1        n  a0        a1        be     wr   wd        rd        er   dc
        add_vec(2'd0, 1'b0, 1'b0, 16'h3001, 16'h0000, 0,  0, 16'hBEEF, 16'h0000, 1, 16'h3000, 16'h0000, 2'b11, 1'b0, 16'h0000, 16'hBEEF, 1'b0, 2);
        add_vec(2'd0, 1'b1, 1'b1, 16'h4001, 16'h0000, 0,  0, 16'h8012, 16'h0000, 1, 16'h4001, 16'h0000, 2'b10, 1'b0, 16'h0000, 16'hFF80, 1'b0, 2);
        add_vec(2'd0, 1'b1, 1'b0, 16'h4001, 16'h0000, 0,  0, 16'h8012, 16'h0000, 1, 16'h4001, 16'h0000, 2'b10, 1'b0, 16'h0000, 16'h0080, 1'b0, 2);
        add_vec(2'd0, 1'b1, 1'b1, 16'h4000, 16'h0000, 2,  0, 16'h8012, 16'h0000, 1, 16'h4000, 16'h0000, 2'b01, 1'b0, 16'h0000, 16'h0012, 1'b0, 4);
        add_vec(2'd1, 1'b1, 1'b0, 16'h4001, 16'h12AB, 3,  0, 16'h0000, 16'h0000, 1, 16'h4001, 16'h0000, 2'b10, 1'b1, 16'hABAB, 16'h0000, 1'b0, 5);
        add_vec(2'd2, 1'b0, 1'b0, 16'h5000, 16'h0000, 0,  0, 16'h6002, 16'h1234, 2, 16'h5000, 16'h6002, 2'b11, 1'b0, 16'h0000, 16'h1234, 1'b0, 3);
        add_vec(2'd0, 1'b0, 1'b0, 16'h1234, 16'h0000, 99, 0, 16'h5555, 16'h0000, 1, 16'h1234, 16'h0000, 2'b11, 1'b0, 16'h0000, 16'h0000, 1'b1, 5);
        add_vec(2'd0, 1'b0, 1'b0, 16'h2001, 16'h0000, 3,  0, 16'hC0DE, 16'h0000, 1, 16'h2000, 16'h0000, 2'b11, 1'b0, 16'h0000, 16'hC0DE, 1'b0, 5);
        add_vec(2'd3, 1'b0, 1'b0, 16'h0A00, 16'h7777, 99, 0, 16'h0000, 16'h0000, 1, 16'h0A00, 16'h0000, 2'b11, 1'b0, 16'h0000, 16'h0000, 1'b1, 5);
        add_vec(2'd1, 1'b0, 1'b0, 16'h2003, 16'h5A5A, 0,  0, 16'h0000, 16'h0000, 1, 16'h2002, 16'h0000, 2'b11, 1'b1, 16'h5A5A, 16'h0000, 1'b0, 2);
        add_vec(2'd2, 1'b1, 1'b0, 16'h7001, 16'h0000, 0, 99, 16'h0103, 16'hFFFF, 2, 16'h7000, 16'h0103, 2'b10, 1'b0, 16'h0000, 16'h0000, 1'b1, 6);
        add_vec(2'd3, 1'b1, 1'b0, 16'h0800, 16'h00C3, 1,  2, 16'h0905, 16'h0000, 2, 16'h0800, 16'h0905, 2'b10, 1'b1, 16'hC3C3, 16'h0000, 1'b0, 6);

        foreach (vecs[i]) begin
            mem[vecs[i].t.addr[15:1]] = vecs[i].v0;
            if (vecs[i].t.op[1]) mem[vecs[i].v0[15:1]] = vecs[i].v1;
            run_txn($sformatf("vec%0d", i), vecs[i].t, o, fl);
            compare($sformatf("vec%0d", i), vecs[i].t, o, vecs[i].e, fl);
        end

        // Reset while a byte store waits for its response.
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b01; req_byte = 1'b1; req_sext = 1'b0;
        req_addr = 16'h4001; req_wdata = 16'h12AB; mem_resp = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rstwr.mem_write_before", 32'(mem_write), 32'd1);
        chk("rstwr.mem_wdata",        32'(mem_wdata), 32'hABAB);
        chk("rstwr.mem_be",           32'(mem_byte_enable), 32'h2);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rstwr.mem_write_after", 32'(mem_write),   32'd0);
        chk("rstwr.done",            32'(done),        32'd0);
        chk("rstwr.req_ready",       32'(req_ready),   32'd1);
        chk("rstwr.mem_addr",        32'(mem_address), 32'd0);
        reset = 1'b0;
        seen  = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done || mem_write || mem_read) seen = 1'b1;
        end
        chk("rstwr.quiet_after", 32'(seen), 32'd0);

        for (int n = 0; n < 300; n++) begin
            t.op    = 2'($urandom);
            t.byt   = 1'($urandom);
            t.sext  = 1'($urandom);
            t.addr  = 16'($urandom);
            t.wdata = 16'($urandom);
            t.d0    = pick_delay();
            t.d1    = pick_delay();
            e = model(t);
            run_txn($sformatf("rnd%0d", n), t, o, fl);
            compare($sformatf("rnd%0d", n), t, o, e, fl);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_sequencer.md
MEM_SEQUENCER -- requirements
Module: mem_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, memory word width in bits (multiple of 8, >= 16).
REQ-002 SHALL have parameter ADDR_W, default 16, address width in bits.
REQ-003 SHALL have parameter TIMEOUT, default 64, maximum wait cycles for mem_resp per access (0 = no timeout).
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk input 1, rising edge.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  sequencer can accept a request.
REQ-008 req_op  input  2  00 load, 01 store, 10 load-indirect, 11 store-indirect.
REQ-009 req_byte  input  1  byte access (1) or word access (0).
REQ-010 req_sext  input  1  sign-extend a byte load (1) or zero-extend it (0).
REQ-011 req_addr  input  ADDR_W  access address (pointer address for indirect ops).
REQ-012 req_wdata  input  DATA_W  store data.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 err  output  1  valid with done; access timed out.
REQ-015 rdata  output  DATA_W  load result, valid with done.
REQ-016 mem_address  output  ADDR_W; mem_read, mem_write  output  1 each; mem_wdata  output  DATA_W; mem_byte_enable  output  DATA_W/8.
REQ-017 mem_rdata  input  DATA_W; mem_resp  input  1.

Function
REQ-018 Lanes: L = DATA_W/8; LB = clog2(L); byte lane = address[LB-1:0].
REQ-019 State machine SHALL have states IDLE, IND, RD, WR, RESP.
REQ-020 IDLE: req_ready=1; on req_valid, latch op, byte, sext, addr and wdata; go to IND if op[1]=1, else RD for load, else WR for store.
REQ-021 req_ready SHALL be 0 in every state except IDLE; req_valid SHALL be ignored outside IDLE.
REQ-022 IND: mem_read=1 with word addressing; on mem_resp, latch mem_rdata[ADDR_W-1:0] as the new address; go to RD (load-indirect) or WR (store-indirect).
REQ-023 RD: mem_read=1; on mem_resp, latch the formatted result into rdata; go to RESP.
REQ-024 WR: mem_write=1; on mem_resp, go to RESP.
REQ-025 RESP: done=1 for exactly one cycle; go to IDLE.
REQ-026 Word accesses SHALL drive mem_address with bits [LB-1:0] cleared and set mem_byte_enable all-ones.
REQ-027 Byte accesses SHALL drive the full address; mem_byte_enable SHALL be one-hot on the lane.
REQ-028 Byte store: mem_wdata = req_wdata[7:0] replicated to all L lanes.
REQ-029 Word store: mem_wdata = req_wdata.
REQ-030 Byte load: rdata = selected lane byte, sign- or zero-extended to DATA_W per sext.
REQ-031 Word load: rdata = mem_rdata.
REQ-032 mem_read and mem_write SHALL never be high together and SHALL be 0 in IDLE and RESP.
REQ-033 mem_address, mem_wdata and mem_byte_enable SHALL be stable while mem_read or mem_write is high.
REQ-034 mem_resp SHALL be ignored in IDLE and RESP.
REQ-035 Latency with zero-wait memory (mem_resp in the first access cycle): done asserts 2 cycles after acceptance for load/store and 3 cycles after for indirect ops.
REQ-036 Timeout: a wait counter SHALL clear on entry to IND, RD or WR. If TIMEOUT>0 and mem_resp has not arrived after TIMEOUT cycles in a state, the FSM SHALL go to RESP with err=1 and rdata=0, and SHALL skip any remaining access.
REQ-037 mem_resp arriving in the TIMEOUT-th cycle SHALL complete normally with err=0.
REQ-038 err SHALL be 0 whenever done is 0.

Reset
REQ-039 Reset SHALL force state IDLE, req_ready=1, and done, err, mem_read, mem_write = 0. It SHALL also clear rdata, mem_address, mem_wdata, mem_byte_enable and the wait counter to 0.
REQ-040 Reset mid-operation SHALL abort the transaction with no done pulse; mem_read and mem_write SHALL be 0 in the cycle after reset is sampled.

Verification
REQ-041 Word load, addr 0x3001, mem_rdata 0xBEEF, zero-wait -> mem_address 0x3000, mem_byte_enable 2'b11, done in cycle 2 with rdata 0xBEEF and err 0.
REQ-042 Byte load, addr 0x4001, mem_rdata 0x8012: sext=1 -> rdata 0xFF80; sext=0 -> rdata 0x0080.
REQ-043 Byte store, addr 0x4001, wdata 0x12AB -> mem_wdata 0xABAB, mem_byte_enable 2'b10, mem_write held through 3 wait cycles until mem_resp.
REQ-044 Load-indirect, addr 0x5000: first read returns 0x6002, second returns 0x1234 -> second mem_address 0x6002, rdata 0x1234, done in cycle 3.
REQ-045 TIMEOUT=4, mem_resp never asserted -> mem_read high exactly 4 cycles, then done=1, err=1, rdata 0x0000; next request accepted.
REQ-046 Reset asserted during WR wait -> mem_write 0 next cycle, no done, req_ready 1.
